// File: rtl/wave_gen_pkg.sv
// Shared constants for the tone generator: mode encodings, LFSR seed/taps
// and the shortest period a channel will run with.
package wave_gen_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_PULSE  = 2'd2,
    MODE_NOISE  = 2'd3
  } mode_e;

  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam int          LFSR_TAP_A = 15;
  localparam int          LFSR_TAP_B = 13;
  localparam int          LFSR_TAP_C = 12;
  localparam int          LFSR_TAP_D = 10;

  localparam int MIN_PERIOD = 2;

  function automatic logic [15:0] lfsrNext(input logic [15:0] s);
    return {s[14:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]};
  endfunction

endpackage

// File: rtl/wave_gen_ch.sv
// One tone channel: configuration registers, phase/length counters, noise
// LFSR and the registered output sample.
module wave_gen_ch
  import wave_gen_pkg::*;
#(
  parameter int PW = 21,
  parameter int VW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          load_i,
  input  logic [1:0]    cfgMode_i,
  input  logic [PW-1:0] cfgPeriod_i,
  input  logic [PW-1:0] cfgDuty_i,
  input  logic [VW-1:0] cfgVolume_i,
  input  logic [15:0]   cfgLen_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [VW-1:0] wave_o
);

  mode_e         mode_q, mode_d;
  logic [PW-1:0] period_q, period_d;
  logic [PW-1:0] duty_q, duty_d;
  logic [VW-1:0] volume_q, volume_d;
  logic [15:0]   len_q, len_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [VW-1:0] wave_q, wave_d;

  logic          wrap;
  logic          high;
  logic [16:0]   cntNext;

  // period_q holds the already-clamped effective period, so wrap needs no clamp
  assign wrap    = (phase_q == period_q - PW'(1));
  assign cntNext = {1'b0, cnt_q} + 17'd1;

  always_comb begin
    high = 1'b0;
    case (mode_q)
      MODE_SQUARE: high = (phase_q < (period_q >> 1));
      MODE_PULSE:  high = (phase_q < duty_q);
      MODE_NOISE:  high = lfsr_q[0];
      default:     high = 1'b0;
    endcase
  end

  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    volume_d = volume_q;
    len_d    = len_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    wave_d   = (busy_q && en_i && high) ? volume_q : '0;

    // A new configuration wins over a coincident final wrap, so no done pulse
    if (load_i) begin
      mode_d   = mode_e'(cfgMode_i);
      period_d = (cfgPeriod_i < PW'(MIN_PERIOD)) ? PW'(MIN_PERIOD) : cfgPeriod_i;
      duty_d   = cfgDuty_i;
      volume_d = cfgVolume_i;
      len_d    = cfgLen_i;
      phase_d  = '0;
      cnt_d    = '0;
      busy_d   = (cfgMode_i != MODE_OFF);
    end else if (!en_i) begin
      phase_d = '0;
    end else if (busy_q) begin
      if (wrap) begin
        phase_d = '0;
        cnt_d   = cntNext[15:0];
        lfsr_d  = lfsrNext(lfsr_q);
        if ((len_q != 16'd0) && (cntNext == {1'b0, len_q})) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end else begin
        phase_d = phase_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= MODE_OFF;
      period_q <= '0;
      duty_q   <= '0;
      volume_q <= '0;
      len_q    <= '0;
      phase_q  <= '0;
      cnt_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wave_q   <= '0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      volume_q <= volume_d;
      len_q    <= len_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wave_q   <= wave_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign wave_o = wave_q;

endmodule

// File: rtl/wave_gen.sv
// Multi-channel tone generator: decodes configuration writes to the channels
// and mixes their samples with a saturating adder.
module wave_gen
  import wave_gen_pkg::*;
#(
  parameter int CH = 4,
  parameter int PW = 21,
  parameter int VW = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic                                 cfg_we,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] cfg_ch,
  input  logic [1:0]                           cfg_mode,
  input  logic [PW-1:0]                        cfg_period,
  input  logic [PW-1:0]                        cfg_duty,
  input  logic [VW-1:0]                        cfg_volume,
  input  logic [15:0]                          cfg_len,
  output logic [CH-1:0]                        busy,
  output logic [CH-1:0]                        done,
  output logic [CH*VW-1:0]                     ch_wave,
  output logic [VW-1:0]                        mix_out
);

  localparam int            CHW     = (CH > 1) ? $clog2(CH) : 1;
  localparam int            SW      = VW + CHW;
  localparam logic [VW-1:0] MIX_MAX = '1;

  logic [CH-1:0] load;
  logic [SW-1:0] sum;
  logic [VW-1:0] mix_q, mix_d;

  // Indices at or beyond CH match no channel, so such writes are dropped
  for (genvar i = 0; i < CH; i++) begin : gCh
    assign load[i] = cfg_we && (cfg_ch == CHW'(i));

    wave_gen_ch #(
      .PW(PW),
      .VW(VW)
    ) uCh (
      .clk        (clk),
      .rst        (rst),
      .en_i       (en),
      .load_i     (load[i]),
      .cfgMode_i  (cfg_mode),
      .cfgPeriod_i(cfg_period),
      .cfgDuty_i  (cfg_duty),
      .cfgVolume_i(cfg_volume),
      .cfgLen_i   (cfg_len),
      .busy_o     (busy[i]),
      .done_o     (done[i]),
      .wave_o     (ch_wave[i*VW +: VW])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < CH; i++) begin
      sum = sum + SW'(ch_wave[i*VW +: VW]);
    end
    mix_d = (sum > SW'(MIX_MAX)) ? MIX_MAX : sum[VW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mix_q <= '0;
    end else begin
      mix_q <= mix_d;
    end
  end

  assign mix_out = mix_q;

endmodule
